hazard_scoreboard: RTL and testbench

//  Producer-side pipeline tracker that pairs with the forwarding unit.

---
 rtl/hazard_scoreboard.sv | 116 +++++++++++
 tb/tb_hazard_scoreboard.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes through the EXE and MEM
// slots and raises the stall/bubble request for the ID stage.
// Optional build macro HAZ_STALL_CNT_EN adds a saturating stall-cycle counter
// (stall_cnt) with a synchronous clear (cnt_clr).
module hazard_scoreboard #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              forward_en,
    input  logic              id_valid,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] id_dest,
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    output logic              stall,
    output logic [REG_AW-1:0] exe_dest,
    output logic              exe_wb_en,
    output logic [REG_AW-1:0] mem_dest,
    output logic              mem_wb_en
`ifdef HAZ_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              cnt_clr
`endif
);

    typedef struct packed {
        logic              v;
        logic              wb;
        logic              ld;
        logic [REG_AW-1:0] dst;
    } exe_slot_t;

    typedef struct packed {
        logic              v;
        logic              wb;
        logic [REG_AW-1:0] dst;
    } mem_slot_t;

    exe_slot_t exe_q, exe_d;
    mem_slot_t mem_q, mem_d;
    logic      exe_hit, mem_hit;

    // Source-vs-slot comparison; WB is not checked because the register file
    // writes in the first half-cycle.
    always_comb begin
        exe_hit = exe_q.v & exe_q.wb &
                  ((src1 == exe_q.dst) | (two_src & (src2 == exe_q.dst)));
        mem_hit = mem_q.v & mem_q.wb &
                  ((src1 == mem_q.dst) | (two_src & (src2 == mem_q.dst)));
    end

    // With forwarding only a load still in EXE cannot be bypassed in time.
    assign stall = id_valid & (forward_en ? (exe_hit & exe_q.ld) : (exe_hit | mem_hit));

    // Slot advance; freeze holds everything, a stall or flush inserts a bubble.
    always_comb begin
        exe_d = exe_q;
        mem_d = mem_q;
        if (!freeze) begin
            mem_d = '{v: exe_q.v, wb: exe_q.wb, dst: exe_q.dst};
            if (stall | flush | !id_valid)
                exe_d = '0;
            else
                exe_d = '{v: 1'b1, wb: id_wb_en, ld: id_mem_read, dst: id_dest};
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_q <= '0;
            mem_q <= '0;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
        end
    end

    assign exe_dest  = exe_q.dst;
    assign exe_wb_en = exe_q.v & exe_q.wb;
    assign mem_dest  = mem_q.dst;
    assign mem_wb_en = mem_q.v & mem_q.wb;

`ifdef HAZ_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count edges where the stall really takes effect; clear wins, saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (stall & !freeze & (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`else
    // CNT_W only sizes the optional counter; keep it referenced in the default build.
    if (CNT_W > 0) begin : g_no_cnt
    end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by
// random traffic, all checked against a queue-based model of in-flight writes.
module tb_hazard_scoreboard;

`ifdef HAZ_STALL_CNT_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 16;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       freeze = 1'b0, flush = 1'b0, forward_en = 1'b0;
    logic       id_valid = 1'b0, id_wb_en = 1'b0, id_mem_read = 1'b0, two_src = 1'b0;
    logic [3:0] id_dest = '0, src1 = '0, src2 = '0;
    logic       stall, exe_wb_en, mem_wb_en;
    logic [3:0] exe_dest, mem_dest;
`ifdef HAZ_STALL_CNT_EN
    logic [TB_CNT_W-1:0] stall_cnt;
    logic                cnt_clr = 1'b0;
`endif

    hazard_scoreboard #(.REG_AW(4), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .forward_en(forward_en), .id_valid(id_valid), .id_wb_en(id_wb_en),
        .id_mem_read(id_mem_read), .id_dest(id_dest), .src1(src1), .src2(src2),
        .two_src(two_src), .stall(stall), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en)
`ifdef HAZ_STALL_CNT_EN
        , .stall_cnt(stall_cnt), .cnt_clr(cnt_clr)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: in-flight writes, pipe[0] is the entry in EXE, pipe[1] in MEM.
    typedef struct packed {
        bit       v;
        bit       wb;
        bit       ld;
        bit [3:0] dst;
    } ent_t;

    ent_t pipe[$];
    int   m_cnt;
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic void m_reset();
        pipe.delete();
        pipe.push_back('0);
        pipe.push_back('0);
        m_cnt = 0;
    endfunction

    function automatic bit m_stall();
        if (!id_valid) return 1'b0;
        for (int i = 0; i < 2; i++) begin
            ent_t e = pipe[i];
            bit hit = e.v && e.wb && (src1 == e.dst || (two_src && src2 == e.dst));
            if (hit && (!forward_en || (i == 0 && e.ld))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void m_edge(input bit st);
        ent_t n;
`ifdef HAZ_STALL_CNT_EN
        if (cnt_clr) m_cnt = 0;
        else if (st && !freeze && m_cnt < (1 << TB_CNT_W) - 1) m_cnt++;
`endif
        if (freeze) return;
        n = '0;
        if (!(st || flush || !id_valid)) n = '{1'b1, id_wb_en, id_mem_read, id_dest};
        void'(pipe.pop_back());
        pipe[0].ld = 1'b0;
        pipe.push_front(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("m_stall", {31'b0, stall}, {31'b0, m_stall()});
        chk("m_exe_dest", {28'b0, exe_dest}, {28'b0, pipe[0].dst});
        chk("m_exe_wb", {31'b0, exe_wb_en}, {31'b0, pipe[0].v & pipe[0].wb});
        chk("m_mem_dest", {28'b0, mem_dest}, {28'b0, pipe[1].dst});
        chk("m_mem_wb", {31'b0, mem_wb_en}, {31'b0, pipe[1].v & pipe[1].wb});
`ifdef HAZ_STALL_CNT_EN
        chk("m_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
    endtask

    // One clock: check at negedge, advance model at posedge, return at posedge+1.
    task automatic step();
        bit st;
        @(negedge clk);
        check_model();
        st = m_stall();
        @(posedge clk);
        m_edge(st);
        #1;
    endtask

    task automatic set_id(input bit v, input bit wb, input bit ld, input int d,
                          input int s1, input int s2, input bit two);
        id_valid = v; id_wb_en = wb; id_mem_read = ld;
        id_dest = 4'(d); src1 = 4'(s1); src2 = 4'(s2); two_src = two;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        freeze = 1'b0; flush = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0);
        #1;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        m_reset();
        // Reset: valid ID write with a self-matching source must not stall
        set_id(1, 1, 0, 3, 3, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 0);
        chk("rst_exe_dest", {28'b0, exe_dest}, 0);
        chk("rst_exe_wb", {31'b0, exe_wb_en}, 0);
        chk("rst_mem_dest", {28'b0, mem_dest}, 0);
        chk("rst_mem_wb", {31'b0, mem_wb_en}, 0);
        rst_n = 1'b1;
        step();
        chk("rel_exe_dest", {28'b0, exe_dest}, 3);
        chk("rel_exe_wb", {31'b0, exe_wb_en}, 1);

        // Load-use with forwarding: one bubble
        do_reset();
        forward_en = 1'b1;
        set_id(1, 1, 1, 2, 0, 0, 0);
        step();
        set_id(1, 1, 0, 4, 2, 1, 1);
        #1 chk("lu_stall", {31'b0, stall}, 1);
        step();
        chk("lu_mem_dest", {28'b0, mem_dest}, 2);
        chk("lu_mem_wb", {31'b0, mem_wb_en}, 1);
        chk("lu_bubble", {31'b0, exe_wb_en}, 0);
        chk("lu_stall_end", {31'b0, stall}, 0);
        step();
        chk("lu_add_exe", {28'b0, exe_dest}, 4);

        // No forwarding: two stall cycles, none without src2
        do_reset();
        forward_en = 1'b0;
        set_id(1, 1, 0, 5, 0, 0, 0);
        step();
        set_id(1, 1, 0, 6, 1, 5, 1);
        #1 chk("nf_stall_exe", {31'b0, stall}, 1);
        step();
        chk("nf_stall_mem", {31'b0, stall}, 1);
        step();
        chk("nf_stall_end", {31'b0, stall}, 0);
        do_reset();
        set_id(1, 1, 0, 5, 0, 0, 0);
        step();
        set_id(1, 1, 0, 6, 1, 5, 0);
        #1 chk("nf_one_src", {31'b0, stall}, 0);
        step();

        // Freeze holds a load-use stall
        do_reset();
        forward_en = 1'b1;
        set_id(1, 1, 1, 2, 0, 0, 0);
        step();
        set_id(1, 1, 0, 4, 2, 0, 0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fz_stall", {31'b0, stall}, 1);
            chk("fz_exe_dest", {28'b0, exe_dest}, 2);
            chk("fz_mem_wb", {31'b0, mem_wb_en}, 0);
        end
        freeze = 1'b0;
        step();
        chk("fz_release", {31'b0, stall}, 0);

        // Flush kills the instruction entering EXE
        do_reset();
        set_id(1, 1, 0, 1, 0, 0, 0);
        step();
        set_id(1, 1, 0, 7, 0, 0, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_exe_wb", {31'b0, exe_wb_en}, 0);
        chk("fl_mem_dest", {28'b0, mem_dest}, 1);
        chk("fl_mem_wb", {31'b0, mem_wb_en}, 1);

        // Reset asserted during a stall drops stall at once
        do_reset();
        set_id(1, 1, 1, 2, 0, 0, 0);
        step();
        set_id(1, 1, 0, 4, 2, 0, 0);
        #1 chk("rs_pre", {31'b0, stall}, 1);
        rst_n = 1'b0;
        #1 chk("rs_drop", {31'b0, stall}, 0);
        m_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef HAZ_STALL_CNT_EN
        // Counter saturation and clear-over-increment
        do_reset();
        forward_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_id(1, 1, 0, 5, 0, 0, 0);
            step();
            set_id(1, 1, 0, 6, 9, 5, 1);
            repeat (3) step();
        end
        chk("cnt_sat", 32'(stall_cnt), 3);
        set_id(1, 1, 0, 5, 0, 0, 0);
        step();
        set_id(1, 1, 0, 6, 9, 5, 1);
        cnt_clr = 1'b1;
        #1 chk("cnt_clr_stall", {31'b0, stall}, 1);
        step();
        cnt_clr = 1'b0;
        chk("cnt_clr", 32'(stall_cnt), 0);
`endif

        // Random traffic over a small register space to provoke hits
        do_reset();
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1);
            freeze = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) forward_en = ~forward_en;
`ifdef HAZ_STALL_CNT_EN
            cnt_clr = ($urandom_range(0, 15) == 0);
`endif
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
